// File: rtl/video_pkg.sv
// Shared definitions for the video gamma/tone-mapping stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package video_pkg;

    // Default bits per colour channel.
    localparam int DEFAULT_COLOR_DEPTH = 8;

    // Cycles from *_in to *_out through the remap pipeline.
    localparam int LUT_LATENCY = 2;

    // Bank-swap controller states.
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } swap_state_e;

    // Width of a channel-select field; never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gamma_lut_bank.sv
// One colour channel's double-buffered remap table: two banks of 2^COLOR_DEPTH entries.
// Latency: 1 cycle registered read; a write is visible to reads from the next cycle.
// Backpressure: none; one write and one read accepted every cycle.
module gamma_lut_bank
    import video_pkg::*;
#(
    parameter int COLOR_DEPTH = DEFAULT_COLOR_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   wr_en_i,
    input  logic                   wr_bank_i,
    input  logic [COLOR_DEPTH-1:0] wr_addr_i,
    input  logic [COLOR_DEPTH-1:0] wr_data_i,
    input  logic                   rd_bank_i,
    input  logic [COLOR_DEPTH-1:0] rd_addr_i,
    output logic [COLOR_DEPTH-1:0] rd_data_o
);

    localparam int ENTRIES = 2 * (2 ** COLOR_DEPTH);

    // Bank select is the address MSB, so both banks share one RAM.
    logic [COLOR_DEPTH-1:0] mem_q [ENTRIES];
    logic [COLOR_DEPTH-1:0] rd_data_q;

    // Write port: no reset so the array maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
        end
    end

    // Registered read port.
    always_ff @(posedge clk_i) begin
        rd_data_q <= mem_q[{rd_bank_i, rd_addr_i}];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/video_gamma_lut.sv
// Per-channel gamma remap with double-buffered tables; bank swap and bypass change only at frame start.
// Latency: 2 pix_clk cycles for pixels and timing, in both LUT and bypass modes.
// Backpressure: none; one pixel per cycle, table writes during a pending swap are dropped with wr_err.
module video_gamma_lut
    import video_pkg::*;
#(
    parameter int   COLOR_DEPTH = DEFAULT_COLOR_DEPTH,
    parameter int   CHANNELS    = 3,
    parameter logic VS_POL      = 1'b1
) (
    input  logic                              pix_clk,
    input  logic                              rst,
    input  logic                              vs_in,
    input  logic                              hs_in,
    input  logic                              de_in,
    input  logic [CHANNELS*COLOR_DEPTH-1:0]   pixel_in,
    output logic                              vs_out,
    output logic                              hs_out,
    output logic                              de_out,
    output logic [CHANNELS*COLOR_DEPTH-1:0]   pixel_out,
    input  logic                              bypass,
    input  logic                              lut_wr_en,
    input  logic [ch_width(CHANNELS)-1:0]     lut_wr_ch,
    input  logic [COLOR_DEPTH-1:0]            lut_wr_addr,
    input  logic [COLOR_DEPTH-1:0]            lut_wr_data,
    input  logic                              lut_swap_req,
    output logic                              swap_pending,
    output logic                              swap_done,
    output logic                              wr_err,
    output logic                              active_bank,
    output logic                              bypass_active
);

    localparam int PW = CHANNELS * COLOR_DEPTH;

    // Frame-boundary detection.
    logic vs_prev_q;
    logic fb;

    // Swap controller.
    swap_state_e state_q, state_d;
    logic        swap_exec;
    logic        pending_w;

    // Control registers.
    logic active_bank_q;
    logic swap_done_q;
    logic bypass_active_q;
    logic wr_err_q, wr_err_d;

    // Write decode.
    logic wr_ch_ok;
    logic wr_accept;

    // Pixel pipeline.
    logic [PW-1:0] lut_rdata;
    logic [PW-1:0] pix_s1_q;
    logic          vs_s1_q, hs_s1_q, de_s1_q;
    logic [PW-1:0] pix_s2_q, pix_s2_d;
    logic          vs_s2_q, hs_s2_q, de_s2_q;

    // A frame starts when vsync enters its active level; the previous-vs
    // register resets to the active level so reset alone never looks like an edge.
    assign fb = (vs_in == VS_POL) && (vs_prev_q != VS_POL);

    // Track the previous vsync level.
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            vs_prev_q <= VS_POL;
        end else begin
            vs_prev_q <= vs_in;
        end
    end

    // Swap FSM state register.
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Swap FSM next state: a request arriving with fb in IDLE waits for the next fb.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (lut_swap_req) state_d = PENDING;
            PENDING: if (fb)           state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Swap FSM outputs.
    always_comb begin
        pending_w = (state_q == PENDING);
        swap_exec = (state_q == PENDING) && fb;
    end

    // Writes go to the shadow bank of a valid channel, and only while no swap is queued.
    always_comb begin
        wr_ch_ok  = (int'(lut_wr_ch) < CHANNELS);
        wr_accept = lut_wr_en && !pending_w && wr_ch_ok;
        wr_err_d  = lut_wr_en && (pending_w || !wr_ch_ok);
    end

    // Bank, bypass and status registers; bank and bypass change only at frame start.
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            active_bank_q   <= 1'b0;
            swap_done_q     <= 1'b0;
            bypass_active_q <= 1'b1;
            wr_err_q        <= 1'b0;
        end else begin
            active_bank_q   <= active_bank_q ^ swap_exec;
            swap_done_q     <= swap_exec;
            wr_err_q        <= wr_err_d;
            if (fb) begin
                bypass_active_q <= bypass;
            end
        end
    end

    // One table per channel; the read address is the raw channel value of the incoming pixel.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        gamma_lut_bank #(
            .COLOR_DEPTH (COLOR_DEPTH)
        ) u_bank (
            .clk_i     (pix_clk),
            .wr_en_i   (wr_accept && (int'(lut_wr_ch) == g)),
            .wr_bank_i (~active_bank_q),
            .wr_addr_i (lut_wr_addr),
            .wr_data_i (lut_wr_data),
            .rd_bank_i (active_bank_q),
            .rd_addr_i (pixel_in[g*COLOR_DEPTH +: COLOR_DEPTH]),
            .rd_data_o (lut_rdata[g*COLOR_DEPTH +: COLOR_DEPTH])
        );
    end

    // Stage-2 pixel source: table output, or the stage-1 copy of the input in bypass.
    always_comb begin
        pix_s2_d = bypass_active_q ? pix_s1_q : lut_rdata;
    end

    // Stage 1 runs in parallel with the table read; timing rides along unchanged.
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            pix_s1_q <= '0;
            vs_s1_q  <= 1'b0;
            hs_s1_q  <= 1'b0;
            de_s1_q  <= 1'b0;
        end else begin
            pix_s1_q <= pixel_in;
            vs_s1_q  <= vs_in;
            hs_s1_q  <= hs_in;
            de_s1_q  <= de_in;
        end
    end

    // Stage 2 registers the remapped pixel and the second timing delay.
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            pix_s2_q <= '0;
            vs_s2_q  <= 1'b0;
            hs_s2_q  <= 1'b0;
            de_s2_q  <= 1'b0;
        end else begin
            pix_s2_q <= pix_s2_d;
            vs_s2_q  <= vs_s1_q;
            hs_s2_q  <= hs_s1_q;
            de_s2_q  <= de_s1_q;
        end
    end

    assign pixel_out     = pix_s2_q;
    assign vs_out        = vs_s2_q;
    assign hs_out        = hs_s2_q;
    assign de_out        = de_s2_q;
    assign swap_pending  = pending_w;
    assign swap_done     = swap_done_q;
    assign wr_err        = wr_err_q;
    assign active_bank   = active_bank_q;
    assign bypass_active = bypass_active_q;

endmodule

// File: tb/tb_video_gamma_lut.sv
// Directed bench for video_gamma_lut: bypass, table load, frame-aligned swap, dropped writes, reset.
// Latency: checks the 2-cycle pixel/timing delay.
// Backpressure: n/a (DUT never stalls).
module tb_video_gamma_lut;

    logic        pix_clk;
    logic        rst;
    logic        vs_in, hs_in, de_in;
    logic [23:0] pixel_in;
    logic        vs_out, hs_out, de_out;
    logic [23:0] pixel_out;
    logic        bypass;
    logic        lut_wr_en;
    logic [1:0]  lut_wr_ch;
    logic [7:0]  lut_wr_addr;
    logic [7:0]  lut_wr_data;
    logic        lut_swap_req;
    logic        swap_pending, swap_done, wr_err, active_bank, bypass_active;

    int n_checks = 0;
    int n_fail   = 0;

    video_gamma_lut #(
        .COLOR_DEPTH (8),
        .CHANNELS    (3),
        .VS_POL      (1'b1)
    ) dut (
        .pix_clk       (pix_clk),
        .rst           (rst),
        .vs_in         (vs_in),
        .hs_in         (hs_in),
        .de_in         (de_in),
        .pixel_in      (pixel_in),
        .vs_out        (vs_out),
        .hs_out        (hs_out),
        .de_out        (de_out),
        .pixel_out     (pixel_out),
        .bypass        (bypass),
        .lut_wr_en     (lut_wr_en),
        .lut_wr_ch     (lut_wr_ch),
        .lut_wr_addr   (lut_wr_addr),
        .lut_wr_data   (lut_wr_data),
        .lut_swap_req  (lut_swap_req),
        .swap_pending  (swap_pending),
        .swap_done     (swap_done),
        .wr_err        (wr_err),
        .active_bank   (active_bank),
        .bypass_active (bypass_active)
    );

    initial pix_clk = 1'b0;
    always #5 pix_clk = ~pix_clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge pix_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one pixel and wait the pipeline latency.
    task automatic send_pix(input logic [23:0] p);
        pixel_in = p;
        de_in    = 1'b1;
        tick();
        tick();
    endtask

    // Fill the shadow bank of all three channels: mode 0 inverts, mode 1 adds one.
    task automatic load_table(input int mode);
        for (int ch = 0; ch < 3; ch++) begin
            for (int a = 0; a < 256; a++) begin
                lut_wr_en   = 1'b1;
                lut_wr_ch   = 2'(ch);
                lut_wr_addr = 8'(a);
                lut_wr_data = (mode == 0) ? 8'(255 - a) : 8'(a + 1);
                tick();
            end
        end
        lut_wr_en = 1'b0;
        tick();
    endtask

    task automatic pulse_swap_req();
        lut_swap_req = 1'b1;
        tick();
        lut_swap_req = 1'b0;
    endtask

    // Raise vsync for one cycle; caller checks the state right after the fb edge.
    task automatic vs_rise();
        vs_in = 1'b1;
        tick();
    endtask

    task automatic vs_fall();
        vs_in = 1'b0;
        tick();
    endtask

    initial begin
        int wr_err_seen;

        rst          = 1'b1;
        vs_in        = 1'b0;
        hs_in        = 1'b0;
        de_in        = 1'b0;
        pixel_in     = 24'h0;
        bypass       = 1'b1;
        lut_wr_en    = 1'b0;
        lut_wr_ch    = 2'd0;
        lut_wr_addr  = 8'h0;
        lut_wr_data  = 8'h0;
        lut_swap_req = 1'b0;
        repeat (3) tick();

        // Reset state.
        check("rst_pixel_out",     32'(pixel_out),     32'h0);
        check("rst_de_out",        32'(de_out),        32'h0);
        check("rst_bypass_active", 32'(bypass_active), 32'h1);
        check("rst_active_bank",   32'(active_bank),   32'h0);
        check("rst_swap_pending",  32'(swap_pending),  32'h0);
        check("rst_swap_done",     32'(swap_done),     32'h0);
        check("rst_wr_err",        32'(wr_err),        32'h0);

        rst = 1'b0;
        tick();

        // Bypass pass-through and 2-cycle latency.
        pixel_in = 24'h123456;
        de_in    = 1'b1;
        hs_in    = 1'b1;
        tick();
        check("lat1_de_out",    32'(de_out),    32'h0);
        check("lat1_pixel_out", 32'(pixel_out), 32'h0);
        tick();
        check("lat2_de_out",    32'(de_out),    32'h1);
        check("lat2_hs_out",    32'(hs_out),    32'h1);
        check("bypass_pixel",   32'(pixel_out), 32'h123456);
        hs_in = 1'b0;

        // Load inverting table into bank 1, then swap with bypass off.
        load_table(0);
        check("load_no_wr_err", 32'(wr_err), 32'h0);
        bypass = 1'b0;
        pulse_swap_req();
        check("req_pending",     32'(swap_pending), 32'h1);
        check("req_bank_held",   32'(active_bank),  32'h0);
        check("req_bypass_held", 32'(bypass_active), 32'h1);
        vs_rise();
        check("swap1_done",      32'(swap_done),     32'h1);
        check("swap1_bank",      32'(active_bank),   32'h1);
        check("swap1_pending",   32'(swap_pending),  32'h0);
        check("swap1_bypass",    32'(bypass_active), 32'h0);
        vs_fall();
        check("swap1_done_pulse", 32'(swap_done), 32'h0);
        send_pix(24'h102030);
        check("invert_pixel", 32'(pixel_out), 32'hEFDFCF);

        // Load add-one table into bank 0 (now the shadow).
        load_table(1);

        // Mid-frame request: bank holds, writes dropped while pending.
        pulse_swap_req();
        repeat (4) tick();
        check("mid_pending",   32'(swap_pending), 32'h1);
        check("mid_bank_held", 32'(active_bank),  32'h1);
        lut_wr_en   = 1'b1;
        lut_wr_ch   = 2'd0;
        lut_wr_addr = 8'h30;
        lut_wr_data = 8'h00;
        tick();
        lut_wr_en = 1'b0;
        check("pend_wr_err", 32'(wr_err), 32'h1);
        tick();
        check("pend_wr_err_pulse", 32'(wr_err), 32'h0);
        send_pix(24'h102030);
        check("mid_pixel_old_bank", 32'(pixel_out), 32'hEFDFCF);
        vs_rise();
        check("swap2_done", 32'(swap_done),   32'h1);
        check("swap2_bank", 32'(active_bank), 32'h0);
        vs_fall();
        send_pix(24'h102030);
        check("addone_pixel_unchanged", 32'(pixel_out), 32'h112131);

        // Request coinciding with fb: no swap now, swap at the next fb.
        vs_in        = 1'b1;
        lut_swap_req = 1'b1;
        tick();
        lut_swap_req = 1'b0;
        check("sim_no_done",  32'(swap_done),    32'h0);
        check("sim_bank",     32'(active_bank),  32'h0);
        check("sim_pending",  32'(swap_pending), 32'h1);
        vs_fall();
        vs_rise();
        check("sim_next_done", 32'(swap_done),   32'h1);
        check("sim_next_bank", 32'(active_bank), 32'h1);
        vs_fall();

        // Valid write to shadow bank 0, then invalid channel write.
        lut_wr_en   = 1'b1;
        lut_wr_ch   = 2'd0;
        lut_wr_addr = 8'h30;
        lut_wr_data = 8'h77;
        tick();
        check("valid_wr_no_err", 32'(wr_err), 32'h0);
        lut_wr_ch   = 2'd3;
        lut_wr_addr = 8'h20;
        lut_wr_data = 8'h00;
        tick();
        lut_wr_en = 1'b0;
        check("badch_wr_err", 32'(wr_err), 32'h1);
        tick();
        check("badch_wr_err_pulse", 32'(wr_err), 32'h0);
        send_pix(24'h102030);
        check("active_bank_untouched", 32'(pixel_out), 32'hEFDFCF);
        pulse_swap_req();
        vs_rise();
        check("swap3_bank", 32'(active_bank), 32'h0);
        vs_fall();
        send_pix(24'h102030);
        check("badch_no_change", 32'(pixel_out), 32'h112177);

        // Bypass change mid-frame has no effect until fb.
        bypass = 1'b1;
        repeat (3) tick();
        check("bypass_mid_held", 32'(bypass_active), 32'h0);
        send_pix(24'h102030);
        check("bypass_mid_pixel", 32'(pixel_out), 32'h112177);
        pulse_swap_req();
        vs_rise();
        check("swap4_bank",   32'(active_bank),   32'h1);
        check("swap4_bypass", 32'(bypass_active), 32'h1);
        vs_fall();
        send_pix(24'h102030);
        check("bypass_on_pixel", 32'(pixel_out), 32'h102030);
        bypass = 1'b0;
        vs_rise();
        check("fb_no_req_done",  32'(swap_done),     32'h0);
        check("fb_no_req_bank",  32'(active_bank),   32'h1);
        check("fb_bypass_off",   32'(bypass_active), 32'h0);
        vs_fall();
        send_pix(24'h102030);
        check("bypass_off_pixel", 32'(pixel_out), 32'hEFDFCF);

        // Reset while a swap is pending cancels it.
        pulse_swap_req();
        check("prerst_pending", 32'(swap_pending), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_pending", 32'(swap_pending),  32'h0);
        check("rst_mid_bank",    32'(active_bank),   32'h0);
        check("rst_mid_bypass",  32'(bypass_active), 32'h1);
        wr_err_seen = 0;
        for (int i = 0; i < 6; i++) begin
            vs_in = (i == 3) ? 1'b1 : 1'b0;
            tick();
            if (swap_done) wr_err_seen++;
        end
        vs_in = 1'b0;
        check("rst_mid_no_swap_done", 32'(wr_err_seen), 32'h0);
        check("rst_mid_bank_after_fb", 32'(active_bank), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
